timer_seq: RTL and testbench

Segment sequencer that drives the control inputs of one `timer` instance (MODE, GO_EN, TOT_CNT, DUTY_CNT). It steps through a programmable table of PWM segments, each with its own period, duty and repeat count, and advances on the timer's IRQ_TRG period-end pulse. It sits beside `timer` in `timer_top`, between the register block and the timer, and produces multi-segment PWM patterns without software intervention per period.

---
 rtl/timer_pkg.sv | 16 +
 rtl/timer_seq_if.sv | 40 ++++
 rtl/timer_seg_mem.sv | 42 ++++
 rtl/timer_seq.sv | 161 ++++++++++++++++
 tb/tb_timer_seq.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer segment sequencer.
package timer_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // Default table geometry and segment entry field widths
    localparam int DEF_NSEG  = 8;
    localparam int DEF_CNT_W = 32;  // period (TOT) and duty field width
    localparam int DEF_RPT_W = 8;   // repeat field width

endpackage

// File: rtl/timer_seq_if.sv
// Table-write, sequence-control and timer-drive signals of timer_seq.
interface timer_seq_if #(
    parameter int NSEG  = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 32,
    parameter int RPT_W = 8
);
    logic             WR_EN;
    logic [IDX_W-1:0] WR_IDX;
    logic [CNT_W-1:0] WR_TOT;
    logic [CNT_W-1:0] WR_DUTY;
    logic [RPT_W-1:0] WR_RPT;
    logic [IDX_W:0]   SEG_NUM;
    logic             LOOP;
    logic             MODE_IN;
    logic             START;
    logic             STOP;
    logic             IRQ_TRG;
    logic             MODE;
    logic             GO_EN;
    logic [CNT_W-1:0] TOT_CNT;
    logic [CNT_W-1:0] DUTY_CNT;
    logic             BUSY;
    logic [IDX_W-1:0] SEG_IDX;
    logic             DONE;

    // Register-block / timer side
    modport master (
        output WR_EN, WR_IDX, WR_TOT, WR_DUTY, WR_RPT, SEG_NUM, LOOP,
               MODE_IN, START, STOP, IRQ_TRG,
        input  MODE, GO_EN, TOT_CNT, DUTY_CNT, BUSY, SEG_IDX, DONE
    );

    // Sequencer side
    modport slave (
        input  WR_EN, WR_IDX, WR_TOT, WR_DUTY, WR_RPT, SEG_NUM, LOOP,
               MODE_IN, START, STOP, IRQ_TRG,
        output MODE, GO_EN, TOT_CNT, DUTY_CNT, BUSY, SEG_IDX, DONE
    );
endinterface

// File: rtl/timer_seg_mem.sv
// Segment table: NSEG entries of {tot, duty, rpt}, sync write, comb read.
module timer_seg_mem #(
    parameter int NSEG  = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 32,
    parameter int RPT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [CNT_W-1:0] wr_tot,
    input  logic [CNT_W-1:0] wr_duty,
    input  logic [RPT_W-1:0] wr_rpt,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_tot,
    output logic [CNT_W-1:0] rd_duty,
    output logic [RPT_W-1:0] rd_rpt
);

    logic [NSEG-1:0][CNT_W-1:0] tot_q;
    logic [NSEG-1:0][CNT_W-1:0] duty_q;
    logic [NSEG-1:0][RPT_W-1:0] rpt_q;

    // Table storage; cleared on reset so a fresh start never sees stale segments
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tot_q  <= '0;
            duty_q <= '0;
            rpt_q  <= '0;
        end else if (wr_en) begin
            tot_q[wr_idx]  <= wr_tot;
            duty_q[wr_idx] <= wr_duty;
            rpt_q[wr_idx]  <= wr_rpt;
        end
    end

    assign rd_tot  = tot_q[rd_idx];
    assign rd_duty = duty_q[rd_idx];
    assign rd_rpt  = rpt_q[rd_idx];

endmodule

// File: rtl/timer_seq.sv
// PWM segment sequencer: walks the segment table and drives one timer's
// MODE/GO_EN/TOT_CNT/DUTY_CNT, advancing on the timer's period-end pulse.
module timer_seq
    import timer_pkg::*;
#(
    parameter int NSEG  = DEF_NSEG,
    parameter int IDX_W = $clog2(NSEG),
    parameter int CNT_W = DEF_CNT_W,
    parameter int RPT_W = DEF_RPT_W
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    timer_seq_if.slave  bus
);

    localparam logic [IDX_W:0] NSEG_V = (IDX_W+1)'(NSEG);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [RPT_W-1:0] lim_q, lim_d;     // repeat limit of the active segment
    logic             mode_q, mode_d;
    logic             go_q, go_d;
    logic [CNT_W-1:0] tot_q, tot_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             busy_q, busy_d;
    logic [IDX_W-1:0] seg_q, seg_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] rd_tot, rd_duty;
    logic [RPT_W-1:0] rd_rpt;
    logic             seg_ok, last_seg;

    timer_seg_mem #(
        .NSEG(NSEG), .IDX_W(IDX_W), .CNT_W(CNT_W), .RPT_W(RPT_W)
    ) u_mem (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .wr_en   (bus.WR_EN),
        .wr_idx  (bus.WR_IDX),
        .wr_tot  (bus.WR_TOT),
        .wr_duty (bus.WR_DUTY),
        .wr_rpt  (bus.WR_RPT),
        .rd_idx  (idx_q),
        .rd_tot  (rd_tot),
        .rd_duty (rd_duty),
        .rd_rpt  (rd_rpt)
    );

    // SEG_NUM is sampled live, so a shrink below idx+1 also counts as last
    assign seg_ok   = (bus.SEG_NUM != '0) && (bus.SEG_NUM <= NSEG_V);
    assign last_seg = ({1'b0, idx_q} + (IDX_W+1)'(1)) >= bus.SEG_NUM;

    // State and registered outputs
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rpt_q   <= '0;
            lim_q   <= '0;
            mode_q  <= 1'b0;
            go_q    <= 1'b0;
            tot_q   <= '0;
            duty_q  <= '0;
            busy_q  <= 1'b0;
            seg_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rpt_q   <= rpt_d;
            lim_q   <= lim_d;
            mode_q  <= mode_d;
            go_q    <= go_d;
            tot_q   <= tot_d;
            duty_q  <= duty_d;
            busy_q  <= busy_d;
            seg_q   <= seg_d;
            done_q  <= done_d;
        end
    end

    // Next state and next outputs; STOP beats IRQ_TRG beats START
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rpt_d   = rpt_q;
        lim_d   = lim_q;
        mode_d  = mode_q;
        go_d    = go_q;
        tot_d   = tot_q;
        duty_d  = duty_q;
        busy_d  = busy_q;
        seg_d   = seg_q;
        done_d  = 1'b0;

        if (bus.STOP) begin
            state_d = S_IDLE;
            go_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    go_d = 1'b0;
                    if (bus.START && seg_ok) begin
                        mode_d  = bus.MODE_IN;
                        idx_d   = '0;
                        rpt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_LOAD;
                    end
                end
                // One GO_EN-low cycle so the timer restarts on every segment
                S_LOAD: begin
                    tot_d   = rd_tot;
                    duty_d  = rd_duty;
                    lim_d   = rd_rpt;
                    seg_d   = idx_q;
                    go_d    = 1'b1;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (bus.IRQ_TRG) begin
                        if (rpt_q < lim_q) begin
                            rpt_d = rpt_q + RPT_W'(1);
                        end else if (!last_seg) begin
                            idx_d   = idx_q + IDX_W'(1);
                            rpt_d   = '0;
                            go_d    = 1'b0;
                            state_d = S_LOAD;
                        end else if (bus.LOOP) begin
                            idx_d   = '0;
                            rpt_d   = '0;
                            go_d    = 1'b0;
                            state_d = S_LOAD;
                        end else begin
                            go_d    = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    go_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.MODE     = mode_q;
    assign bus.GO_EN    = go_q;
    assign bus.TOT_CNT  = tot_q;
    assign bus.DUTY_CNT = duty_q;
    assign bus.BUSY     = busy_q;
    assign bus.SEG_IDX  = seg_q;
    assign bus.DONE     = done_q;

endmodule

// File: tb/tb_timer_seq.sv
// Randomised and directed bench for timer_seq against a period-schedule model.
module tb_timer_seq;
    localparam int NSEG  = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 32;
    localparam int RPT_W = 8;

    logic PCLK;
    logic PRESETn;
    int   n_chk;
    int   n_err;

    // Reference copy of the segment table
    logic [CNT_W-1:0] m_tot  [NSEG];
    logic [CNT_W-1:0] m_duty [NSEG];
    int               m_rpt  [NSEG];

    timer_seq_if #(.NSEG(NSEG), .IDX_W(IDX_W), .CNT_W(CNT_W), .RPT_W(RPT_W)) bus ();

    timer_seq #(.NSEG(NSEG), .IDX_W(IDX_W), .CNT_W(CNT_W), .RPT_W(RPT_W)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wr_entry(input int i, input logic [CNT_W-1:0] tot,
                            input logic [CNT_W-1:0] duty, input int rpt);
        bus.WR_EN   = 1'b1;
        bus.WR_IDX  = IDX_W'(i);
        bus.WR_TOT  = tot;
        bus.WR_DUTY = duty;
        bus.WR_RPT  = RPT_W'(rpt);
        m_tot[i]  = tot;
        m_duty[i] = duty;
        m_rpt[i]  = rpt;
        @(negedge PCLK);
        bus.WR_EN = 1'b0;
    endtask

    // Start a sequence and follow it period by period. The expected schedule
    // is the table flattened into one list of segment indices per period.
    // IRQ_TRG fires on the gap-th RUN cycle of each period; stop_p >= 0 raises
    // STOP together with IRQ_TRG at the end of that period.
    task automatic run_seq(input int n, input bit lp, input bit md, input int gap,
                           input int stop_p, input bit poke_start);
        int sseg[$];
        bit slast[$];
        int len, p, s, q;
        bit fin;
        for (int k = 0; k < n; k++)
            for (int r = 0; r <= m_rpt[k]; r++) begin
                sseg.push_back(k);
                slast.push_back(r == m_rpt[k]);
            end
        len = sseg.size();
        bus.SEG_NUM = (IDX_W+1)'(n);
        bus.LOOP    = lp;
        bus.MODE_IN = md;
        bus.START   = 1'b1;
        @(negedge PCLK);
        bus.START = 1'b0;
        chk("load0_go",   64'(bus.GO_EN), 64'(0));
        chk("load0_busy", 64'(bus.BUSY),  64'(1));
        chk("load0_mode", 64'(bus.MODE),  64'(md));
        p = 0;
        forever begin
            q = p % len;
            s = sseg[q];
            for (int j = 0; j < gap; j++) begin
                @(negedge PCLK);
                bus.IRQ_TRG = 1'b0;
                bus.START   = 1'b0;
                chk("run_go",   64'(bus.GO_EN),    64'(1));
                chk("run_seg",  64'(bus.SEG_IDX),  64'(s));
                chk("run_tot",  64'(bus.TOT_CNT),  64'(m_tot[s]));
                chk("run_duty", 64'(bus.DUTY_CNT), 64'(m_duty[s]));
                chk("run_busy", 64'(bus.BUSY),     64'(1));
                chk("run_done", 64'(bus.DONE),     64'(0));
                if (poke_start && j == 0) bus.START = 1'b1;
                if (j == gap - 1) begin
                    bus.IRQ_TRG = 1'b1;
                    if (p == stop_p) bus.STOP = 1'b1;
                end
            end
            if (p == stop_p) begin
                @(negedge PCLK);
                bus.IRQ_TRG = 1'b0;
                bus.STOP    = 1'b0;
                chk("stop_go",   64'(bus.GO_EN),   64'(0));
                chk("stop_busy", 64'(bus.BUSY),    64'(0));
                chk("stop_done", 64'(bus.DONE),    64'(0));
                chk("stop_seg",  64'(bus.SEG_IDX), 64'(s));
                chk("stop_tot",  64'(bus.TOT_CNT), 64'(m_tot[s]));
                return;
            end
            fin = !lp && (p == len - 1);
            if (slast[q]) begin
                @(negedge PCLK);
                bus.IRQ_TRG = 1'b0;
                chk("end_go",   64'(bus.GO_EN), 64'(0));
                chk("end_done", 64'(bus.DONE),  64'(fin));
                chk("end_busy", 64'(bus.BUSY),  64'(!fin));
                if (fin) begin
                    @(negedge PCLK);
                    chk("done_pulse", 64'(bus.DONE), 64'(0));
                    chk("idle_go",    64'(bus.GO_EN), 64'(0));
                    return;
                end
            end
            p++;
            if (p > 4000) begin
                chk("runaway", 64'(p), 64'(0));
                return;
            end
        end
    endtask

    initial begin
        int len, n, gap, stop_p;
        bit lp, reached;
        n_chk = 0;
        n_err = 0;
        PRESETn = 1'b0;
        bus.WR_EN = 1'b0; bus.WR_IDX = '0; bus.WR_TOT = '0; bus.WR_DUTY = '0;
        bus.WR_RPT = '0; bus.SEG_NUM = '0; bus.LOOP = 1'b0; bus.MODE_IN = 1'b0;
        bus.START = 1'b0; bus.STOP = 1'b0; bus.IRQ_TRG = 1'b0;
        for (int i = 0; i < NSEG; i++) begin
            m_tot[i] = '0; m_duty[i] = '0; m_rpt[i] = 0;
        end
        repeat (3) @(negedge PCLK);
        chk("rst_go",   64'(bus.GO_EN),    64'(0));
        chk("rst_busy", 64'(bus.BUSY),     64'(0));
        chk("rst_tot",  64'(bus.TOT_CNT),  64'(0));
        chk("rst_duty", 64'(bus.DUTY_CNT), 64'(0));
        chk("rst_seg",  64'(bus.SEG_IDX),  64'(0));
        chk("rst_mode", 64'(bus.MODE),     64'(0));
        chk("rst_done", 64'(bus.DONE),     64'(0));
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Single segment: GO_EN cycles 2..12, DONE at 13
        wr_entry(0, 32'd10, 32'd5, 0);
        run_seq(1, 1'b0, 1'b0, 11, -1, 1'b0);

        // Three segments with repeats 1,0,2
        wr_entry(0, 32'd100, 32'd40, 1);
        wr_entry(1, 32'd200, 32'd50, 0);
        wr_entry(2, 32'd300, 32'd60, 2);
        run_seq(3, 1'b0, 1'b1, 20, -1, 1'b0);

        // Looping two segments, five segment ends, START pokes while busy
        wr_entry(0, 32'd11, 32'd1, 0);
        wr_entry(1, 32'd22, 32'd2, 0);
        run_seq(2, 1'b1, 1'b0, 4, 5, 1'b1);

        // STOP together with a segment-final IRQ_TRG
        wr_entry(0, 32'd100, 32'd40, 1);
        run_seq(3, 1'b0, 1'b0, 3, 2, 1'b0);

        // Invalid SEG_NUM values and STOP+START in IDLE
        for (int k = 0; k < 3; k++) begin
            bus.SEG_NUM = (k == 0) ? 4'd0 : (k == 1) ? 4'd9 : 4'd1;
            bus.STOP    = (k == 2);
            bus.START   = 1'b1;
            @(negedge PCLK);
            bus.START = 1'b0;
            bus.STOP  = 1'b0;
            chk("nostart_busy", 64'(bus.BUSY), 64'(0));
            @(negedge PCLK);
            chk("nostart_busy2", 64'(bus.BUSY),  64'(0));
            chk("nostart_go",    64'(bus.GO_EN), 64'(0));
            chk("nostart_done",  64'(bus.DONE),  64'(0));
        end

        // Largest repeat count: 256 periods of one segment
        wr_entry(0, 32'd7, 32'd3, 255);
        run_seq(1, 1'b0, 1'b1, 2, -1, 1'b0);

        // Randomised tables and sequences
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < NSEG; i++)
                wr_entry(i, $urandom, $urandom, int'($urandom_range(0, 3)));
            n   = int'($urandom_range(1, NSEG));
            lp  = 1'($urandom_range(0, 1));
            gap = int'($urandom_range(2, 5));
            len = 0;
            for (int k = 0; k < n; k++) len += m_rpt[k] + 1;
            if (lp)
                stop_p = int'($urandom_range(len, 2 * len));
            else if ($urandom_range(0, 3) == 0)
                stop_p = int'($urandom_range(0, len - 1));
            else
                stop_p = -1;
            run_seq(n, lp, 1'($urandom_range(0, 1)), gap, stop_p, 1'($urandom_range(0, 1)));
            @(negedge PCLK);
        end

        // Asynchronous reset while segment 2 runs, then table must read back 0
        wr_entry(0, 32'd5, 32'd1, 0);
        wr_entry(1, 32'd6, 32'd2, 0);
        wr_entry(2, 32'd9, 32'd4, 0);
        bus.SEG_NUM = 4'd3;
        bus.LOOP    = 1'b1;
        bus.START   = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge PCLK);
            bus.START   = 1'b0;
            bus.IRQ_TRG = 1'b0;
            if (bus.SEG_IDX == 3'd2 && bus.GO_EN) begin
                reached = 1'b1;
                break;
            end
            if (c % 3 == 2) bus.IRQ_TRG = 1'b1;
        end
        chk("reach_seg2", 64'(reached), 64'(1));
        #2 PRESETn = 1'b0;
        #1;
        chk("arst_go",   64'(bus.GO_EN),    64'(0));
        chk("arst_busy", 64'(bus.BUSY),     64'(0));
        chk("arst_seg",  64'(bus.SEG_IDX),  64'(0));
        chk("arst_tot",  64'(bus.TOT_CNT),  64'(0));
        chk("arst_duty", 64'(bus.DUTY_CNT), 64'(0));
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int i = 0; i < NSEG; i++) begin
            m_tot[i] = '0; m_duty[i] = '0; m_rpt[i] = 0;
        end
        @(negedge PCLK);
        run_seq(1, 1'b0, 1'b0, 3, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
